// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between producers/issue stage and the register-file write arbiter.
// Handshake: a request is accepted on a rising edge where req_valid[i] & req_ready[i]; req_valid must not depend on req_ready.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][4:0]   req_rd;
  logic [NREQ-1:0][63:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   hold;
  logic                   resv_valid;
  logic [4:0]             resv_rd;
  logic                   reg_w_ctrl;
  logic [4:0]             reg_w;
  logic [63:0]            w_data;
  logic [31:0]            busy;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       dbg_ptr;

  modport master (
    output req_valid, req_rd, req_data, hold, resv_valid, resv_rd,
    input  req_ready, reg_w_ctrl, reg_w, w_data, busy, grant_idx, dbg_ptr
  );

  modport slave (
    input  req_valid, req_rd, req_data, hold, resv_valid, resv_rd,
    output req_ready, reg_w_ctrl, reg_w, w_data, busy, grant_idx, dbg_ptr
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter with a registered register-file write stage
// and a busy-bit scoreboard of destinations that still have a producer in flight.
module rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic         clk,
  input  logic         rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             wctrl_q, wctrl_d;
  logic [4:0]       wrd_q, wrd_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [31:0]      busy_q, busy_d;

  logic [NREQ-1:0]  win;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  logic             accept;

  // Two passes: indices at or above ptr first, then the wrapped-around ones.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i] && (IDX_W'(i) >= ptr_q)) begin
        found   = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found   = 1'b1;
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  assign bus.req_ready = win & {NREQ{~bus.hold & rst}};
  assign accept        = found & ~bus.hold & rst;

  always_comb begin
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    wctrl_d     = 1'b0;
    wrd_d       = wrd_q;
    wdata_d     = wdata_q;
    if (accept) begin
      ptr_d       = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
      grant_idx_d = win_idx;
      wrd_d       = bus.req_rd[win_idx];
      wdata_d     = bus.req_data[win_idx];
      wctrl_d     = (bus.req_rd[win_idx] != 5'd0);
    end
  end

  // Reservation is applied after the write-back clear so a same-cycle re-reserve keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wctrl_q) begin
      busy_d[wrd_q] = 1'b0;
    end
    if (bus.resv_valid && (bus.resv_rd != 5'd0)) begin
      busy_d[bus.resv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      wctrl_q     <= 1'b0;
      wrd_q       <= 5'd0;
      wdata_q     <= 64'd0;
      busy_q      <= 32'd0;
    end else begin
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      wctrl_q     <= wctrl_d;
      wrd_q       <= wrd_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.reg_w_ctrl = wctrl_q;
  assign bus.reg_w      = wrd_q;
  assign bus.w_data     = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.grant_idx  = grant_idx_q;
  assign bus.dbg_ptr    = ptr_q;
endmodule
